// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry defaults, fill FSM encoding, address packing.
package fb_pkg;

  localparam int unsigned FB_X_WIDTH    = 8;
  localparam int unsigned FB_Y_WIDTH    = 8;
  localparam int unsigned FB_ADDR_WIDTH = FB_X_WIDTH + FB_Y_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // Frame-buffer word address is {row, col}; the display reader packs identically.
  function automatic logic [FB_ADDR_WIDTH-1:0] fb_pack_addr(
    input logic [FB_Y_WIDTH-1:0] row,
    input logic [FB_X_WIDTH-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/fb_rect_fill.sv
// Rectangle-fill writer: accepts one clipped fill command and streams one RAM write per cycle.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int unsigned X_WIDTH = FB_X_WIDTH,
  parameter int unsigned Y_WIDTH = FB_Y_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [X_WIDTH-1:0]         cmd_x,
  input  logic [Y_WIDTH-1:0]         cmd_y,
  input  logic [X_WIDTH:0]           cmd_w,
  input  logic [Y_WIDTH:0]           cmd_h,
  input  logic [31:0]                cmd_color,
  output logic [X_WIDTH+Y_WIDTH-1:0] ram_addr,
  output logic [31:0]                ram_din,
  output logic                       ram_we,
  output logic                       busy,
  output logic                       done
);

  // Clip a span to the space remaining before the frame edge (no wrap-around).
  function automatic logic [X_WIDTH:0] clip_w(input logic [X_WIDTH:0] w, input logic [X_WIDTH-1:0] x);
    logic [X_WIDTH:0] room;
    room = {1'b1, {X_WIDTH{1'b0}}} - {1'b0, x};
    return (w < room) ? w : room;
  endfunction

  function automatic logic [Y_WIDTH:0] clip_h(input logic [Y_WIDTH:0] h, input logic [Y_WIDTH-1:0] y);
    logic [Y_WIDTH:0] room;
    room = {1'b1, {Y_WIDTH{1'b0}}} - {1'b0, y};
    return (h < room) ? h : room;
  endfunction

  fill_state_e        state, state_d;
  logic [X_WIDTH-1:0] x0, x0_d, x_last, x_last_d, col, col_d;
  logic [Y_WIDTH-1:0] y_last, y_last_d, row, row_d;
  logic [31:0]        din_d;
  logic               we_d, busy_d, done_d;
  logic [X_WIDTH:0]   ew;
  logic [Y_WIDTH:0]   eh;
  logic               accept;

  assign ew        = clip_w(cmd_w, cmd_x);
  assign eh        = clip_h(cmd_h, cmd_y);
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  // Same {row, col} packing as fb_pack_addr, kept generic over the geometry parameters.
  assign ram_addr  = {row, col};

  // State, counters and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x0      <= '0;
      x_last  <= '0;
      y_last  <= '0;
      col     <= '0;
      row     <= '0;
      ram_din <= '0;
      ram_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      x0      <= x0_d;
      x_last  <= x_last_d;
      y_last  <= y_last_d;
      col     <= col_d;
      row     <= row_d;
      ram_din <= din_d;
      ram_we  <= we_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; the raster walks columns first, then rows.
  always_comb begin
    state_d  = state;
    x0_d     = x0;
    x_last_d = x_last;
    y_last_d = y_last;
    col_d    = col;
    row_d    = row;
    din_d    = ram_din;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          x0_d     = cmd_x;
          col_d    = cmd_x;
          row_d    = cmd_y;
          din_d    = cmd_color;
          x_last_d = X_WIDTH'({1'b0, cmd_x} + ew - (X_WIDTH+1)'(1));
          y_last_d = Y_WIDTH'({1'b0, cmd_y} + eh - (Y_WIDTH+1)'(1));
          busy_d   = 1'b1;
          if ((ew != '0) && (eh != '0)) begin
            state_d = FILL;
            we_d    = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      FILL: begin
        busy_d = 1'b1;
        if ((col == x_last) && (row == y_last)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          we_d = 1'b1;
          if (col == x_last) begin
            col_d = x0;
            row_d = row + Y_WIDTH'(1);
          end else begin
            col_d = col + X_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill with a behavioural frame-buffer RAM on the write port.
module tb_fb_rect_fill;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [31:0] cmd_color;
  logic [15:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int wr_total = 0;
  logic [31:0] mem [0:65535];

  typedef struct {
    string       name;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [8:0]  w;
    logic [8:0]  h;
    logic [31:0] color;
    int          ew;
    int          eh;
  } vec_t;

  vec_t vecs [6];

  fb_rect_fill dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-buffer RAM write port model.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_total      <= wr_total + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one command with cmd_valid held until done, then check the whole write stream.
  task automatic run_cmd(input vec_t v);
    int t, k, nexp, nwr, first_we, last_we, done_cyc, done_cnt, ready_cyc, addr_err, data_err, gaps;
    logic [15:0] ea;
    logic [15:0] a_first;
    logic [15:0] a_last;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({v.name, "_ready_wait"}, longint'(cmd_ready), 1);
    cmd_x     = v.x;
    cmd_y     = v.y;
    cmd_w     = v.w;
    cmd_h     = v.h;
    cmd_color = v.color;
    cmd_valid = 1'b1;
    @(posedge clk);
    nexp = v.ew * v.eh;
    nwr = 0; first_we = -1; last_we = -1; done_cyc = -1; done_cnt = 0;
    ready_cyc = -1; addr_err = 0; data_err = 0; gaps = 0; k = 0;
    while (ready_cyc < 0 && k < 70000) begin
      @(negedge clk);
      k++;
      if (ram_we) begin
        if (first_we < 0) first_we = k;
        else if (k != last_we + 1) gaps++;
        last_we = k;
        if (nwr < nexp) begin
          ea = 16'((int'(v.y) + nwr / v.ew) * 256 + int'(v.x) + nwr % v.ew);
          if (ram_addr !== ea) addr_err++;
        end else begin
          addr_err++;
        end
        if (ram_din !== v.color) data_err++;
        nwr++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = k;
          cmd_valid = 1'b0;
        end
      end
      if (cmd_ready && ready_cyc < 0) ready_cyc = k;
    end
    cmd_valid = 1'b0;
    chk({v.name, "_writes"},    nwr, nexp);
    chk({v.name, "_first_we"},  first_we, (nexp > 0) ? 1 : -1);
    chk({v.name, "_done_cyc"},  done_cyc, nexp + 1);
    chk({v.name, "_done_cnt"},  done_cnt, 1);
    chk({v.name, "_ready_cyc"}, ready_cyc, nexp + 2);
    chk({v.name, "_addr_err"},  addr_err, 0);
    chk({v.name, "_data_err"},  data_err, 0);
    chk({v.name, "_we_gaps"},   gaps, 0);
    if (nexp > 0) begin
      a_first = 16'(int'(v.y) * 256 + int'(v.x));
      a_last  = 16'((int'(v.y) + v.eh - 1) * 256 + int'(v.x) + v.ew - 1);
      chk({v.name, "_rb_first"}, mem[a_first], v.color);
      chk({v.name, "_rb_last"},  mem[a_last],  v.color);
    end
  endtask

  initial begin
    int w0, cnt;
    vec_t v1;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    vecs[0] = '{"basic",   8'd10,  8'd5,   9'd3, 9'd2,  32'hDEADBEEF, 3, 2};
    vecs[1] = '{"corner",  8'd254, 8'd255, 9'd5, 9'd4,  32'hC0FFEE01, 2, 1};
    vecs[2] = '{"zero_w",  8'd0,   8'd0,   9'd0, 9'd7,  32'h11111111, 0, 7};
    vecs[3] = '{"one",     8'd100, 8'd200, 9'd1, 9'd1,  32'h0BADF00D, 1, 1};
    vecs[4] = '{"fit_x",   8'd250, 8'd3,   9'd6, 9'd2,  32'h5A5A5A5A, 6, 2};
    vecs[5] = '{"clip_y",  8'd8,   8'd250, 9'd4, 9'd10, 32'h87654321, 4, 6};

    // Reset state.
    @(negedge clk);
    chk("rst_we",    ram_we, 0);
    chk("rst_addr",  ram_addr, 0);
    chk("rst_din",   ram_din, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Clipping must never wrap to column 0 or row 0.
    chk("clip_no_ff00", mem[16'hFF00], 0);
    chk("clip_no_0000", mem[16'h0000], 0);
    chk("clip_total",   wr_total, 6 + 2 + 0 + 1 + 12 + 24);

    // Reset after the third write of a 4x4 fill.
    @(negedge clk);
    w0 = wr_total;
    cmd_x = 8'd20; cmd_y = 8'd30; cmd_w = 9'd4; cmd_h = 9'd4;
    cmd_color = 32'h12345678; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_we",    ram_we, 0);
    chk("abort_addr",  ram_addr, 0);
    chk("abort_din",   ram_din, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_done",  done, 0);
    chk("abort_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    chk("abort_we_hold", ram_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", cmd_ready, 1);
    chk("abort_writes", wr_total - w0, 3);
    cnt = 0;
    for (int r = 30; r < 34; r++)
      for (int c = 20; c < 24; c++)
        if (mem[r * 256 + c] == 32'h12345678) cnt++;
    chk("abort_region", cnt, 3);

    v1 = '{"post_rst", 8'd7, 8'd9, 9'd1, 9'd1, 32'hA5A50F0F, 1, 1};
    run_cmd(v1);

    // Full-frame fill with cmd_valid held through FILL.
    v1 = '{"full", 8'd0, 8'd0, 9'd256, 9'd256, 32'hFEEDFACE, 256, 256};
    run_cmd(v1);
    chk("full_mid", mem[16'h8000], 32'hFEEDFACE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Rectangle-fill writer sitting directly upstream of the frame-buffer dual-port RAM, driving its write port (address, data, write enable). It accepts a fill command (origin, size, 32-bit colour) over a valid/ready handshake. It then emits one write per cycle in row-major order, clipping the rectangle to the frame edges. The display reader on the RAM's other port is unaffected; this block only writes.

## Interface
- `X_WIDTH`, 8, column bits; frame is 2**X_WIDTH words wide.
- `Y_WIDTH`, 8, row bits; frame is 2**Y_WIDTH rows. X_WIDTH+Y_WIDTH equals the RAM ADDR_WIDTH (16).

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept; high only in IDLE and not in reset.
- `cmd_x`  in  X_WIDTH  left column.
- `cmd_y`  in  Y_WIDTH  top row.
- `cmd_w`  in  X_WIDTH+1  width in words (0..2**X_WIDTH).
- `cmd_h`  in  Y_WIDTH+1  height in rows (0..2**Y_WIDTH).
- `cmd_color`  in  32  fill word.
- `ram_addr`  out  X_WIDTH+Y_WIDTH  write address, {row, col}.
- `ram_din`  out  32  write data.
- `ram_we`  out  1  write strobe.
- `busy`  out  1  high in FILL and DONE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- Handshake: transfer when `cmd_valid && cmd_ready` at a posedge. Command fields are captured only then and ignored otherwise.
- Clipping at acceptance: `ew = min(cmd_w, 2**X_WIDTH - cmd_x)` and `eh = min(cmd_h, 2**Y_WIDTH - cmd_y)`, computed in X_WIDTH+1 / Y_WIDTH+1 bits. No wrap-around to column 0 or row 0 ever occurs.
- FSM states: IDLE, FILL, DONE.
  - IDLE -> FILL on accept with ew≠0 and eh≠0.
  - IDLE -> DONE on accept with ew=0 or eh=0; no writes are issued.
  - FILL -> DONE after the write at (x0+ew-1, y0+eh-1).
  - DONE -> IDLE unconditionally.
- FILL order: column increments each cycle. After column x0+ew-1, column returns to x0 and row increments. Exactly ew*eh writes, one per cycle, all carrying the captured colour.
- `done` is high exactly in the DONE state.
- Outputs `ram_addr`, `ram_din`, `ram_we`, `busy` and `done` are registered.
- Reset values: state IDLE, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `busy`=0, `done`=0, `cmd_ready`=0 while `rst` is high.
- Reset mid-FILL aborts immediately: `ram_we` drops asynchronously and no further writes occur. Writes already performed stand.

## Timing
- Accept at edge N. First write is presented in cycle N+1 (`ram_we`=1) and committed by the RAM at edge N+1.
- Last of ew*eh writes is in cycle N+ew*eh. `done` is high in cycle N+ew*eh+1. `cmd_ready` is high again in cycle N+ew*eh+2.
- Zero-area command: `done` is high in cycle N+1 and `cmd_ready` is high in cycle N+2.
- `ram_we` never gaps within a command. No back-to-back commands: at least the DONE cycle separates them.

## Structure
- Shared package `fb_pkg` holds:
  - state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2);
  - default X_WIDTH/Y_WIDTH;
  - the `{row,col}` address-packing convention, used identically by the display reader.
- No sub-module. Clipping is a small inline function and the counters and FSM are in one module.

## Test plan
- x=10, y=5, w=3, h=2, colour 0xDEADBEEF -> addresses 0x050A,0x050B,0x050C,0x060A,0x060B,0x060C on consecutive cycles; `done` one cycle after the last write; RAM readback matches.
- x=254, y=255, w=5, h=4 -> clipped to 2x1: writes 0xFFFE,0xFFFF only; no write to 0xFF00 or 0x0000.
- w=0, h=7 -> zero writes, `done` in cycle N+1, `cmd_ready` in cycle N+2.
- x=0, y=0, w=256, h=256 -> 65536 contiguous writes 0x0000..0xFFFF, `ram_we` never gaps; `cmd_valid` held high during FILL is not accepted.
- Assert `rst` after the 3rd write of a 4x4 fill -> `ram_we`=0 immediately, all outputs reset; after release `cmd_ready`=1 and a new 1x1 command writes correctly.
